// File: rtl/ex_alu_arb_if.sv
// Bundles the two requester handshakes, the ALU drive/return and the response channel.
// Latency: none, wiring only.
// Backpressure: carries the req*_ready and rsp_ready signals between the arbiter and its peers.
interface ex_alu_arb_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 4,
    parameter int TAGW = 3
);
    // Port 0: main pipeline issue
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [TAGW-1:0] req0_tag;

    // Port 1: address-generation / branch-target helper
    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_op;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [TAGW-1:0] req1_tag;

    // Shared ALU
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    // Tagged response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_src;

    // Environment side: requesters, the ALU itself and the response consumer
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  rsp_valid, rsp_result, rsp_tag, rsp_src,
        output rsp_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output rsp_valid, rsp_result, rsp_tag, rsp_src,
        input  rsp_ready
    );
endinterface

// File: rtl/ex_alu_arb.sv
// Round-robin share of the single execute-stage ALU between pipeline issue (port 0) and AGU/branch helper (port 1).
// Latency: accept to rsp_valid is 2 cycles; one op per 2 cycles, back-to-back when accept meets the response handshake.
// Backpressure: req readys are low while an op is executing or a response waits on rsp_ready; flush drops everything.
module ex_alu_arb #(
    parameter int XLEN = 64,
    parameter int OPW  = 4,
    parameter int TAGW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    ex_alu_arb_if.slave     bus
);

    // Operation held on the ALU from accept until the next accept
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [TAGW-1:0] tag;
        logic            src;
    } cap_t;

    // Registered response payload
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [TAGW-1:0] tag;
        logic            src;
    } rsp_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       rsp_vld_q, rsp_vld_d;
    cap_t       cap_q, cap_d;
    rsp_t       rsp_q, rsp_d;

    logic       can_accept;
    logic       grant;
    logic       acc0;
    logic       acc1;
    logic       accept;
    logic       rsp_load;

    // New work may enter when idle, or when the held response is consumed this same cycle
    assign can_accept = !flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));

    // Lone requester always wins; on a tie the port not served last time wins
    always_comb begin
        grant = ~last_grant_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
    end

    assign bus.req0_ready = can_accept && !grant;
    assign bus.req1_ready = can_accept && grant;

    assign acc0   = bus.req0_valid && bus.req0_ready;
    assign acc1   = bus.req1_valid && bus.req1_ready;
    assign accept = acc0 || acc1;

    // Select the granted port's payload for capture
    always_comb begin
        cap_d = cap_q;
        if (acc1) begin
            cap_d.op  = bus.req1_op;
            cap_d.a   = bus.req1_a;
            cap_d.b   = bus.req1_b;
            cap_d.tag = bus.req1_tag;
            cap_d.src = 1'b1;
        end else if (acc0) begin
            cap_d.op  = bus.req0_op;
            cap_d.a   = bus.req0_a;
            cap_d.b   = bus.req0_b;
            cap_d.tag = bus.req0_tag;
            cap_d.src = 1'b0;
        end
    end

    // Round-robin pointer only moves on an actual handshake
    assign last_grant_d = accept ? grant : last_grant_q;

    // Next-state and response-valid decode; flush overrides every state
    always_comb begin
        state_d   = state_q;
        rsp_vld_d = rsp_vld_q;
        if (flush) begin
            state_d   = ST_IDLE;
            rsp_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d   = ST_RESP;
                    rsp_vld_d = 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_d   = accept ? ST_EXEC : ST_IDLE;
                        rsp_vld_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b0;
                end
            endcase
        end
    end

    // ALU result is sampled only at the end of the execute cycle
    assign rsp_load = (state_q == ST_EXEC) && !flush;

    // Build the response payload from the ALU output and the captured tag/source
    always_comb begin
        rsp_d = rsp_q;
        if (rsp_load) begin
            rsp_d.result = bus.alu_result;
            rsp_d.tag    = cap_q.tag;
            rsp_d.src    = cap_q.src;
        end
    end

    // Control state: FSM, arbitration pointer, response valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_vld_q    <= rsp_vld_d;
        end
    end

    // Capture registers; they also drive the ALU so its inputs stay quiet between ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    // Response payload registers, stable while the response waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign bus.alu_op     = cap_q.op;
    assign bus.alu_a      = cap_q.a;
    assign bus.alu_b      = cap_q.b;

    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_result = rsp_q.result;
    assign bus.rsp_tag    = rsp_q.tag;
    assign bus.rsp_src    = rsp_q.src;

    // At most one requester is offered ready in any cycle
    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.req0_ready && bus.req1_ready));

    // A stalled response must not change underneath the consumer
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready && !flush) |=>
            (bus.rsp_valid && $stable(rsp_q)));

    // Execute lasts exactly one cycle and ends in RESP, or IDLE when flushed
    a_exec_exit: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_EXEC) |=>
            ((state_q == ST_RESP) || ((state_q == ST_IDLE) && $past(flush))));

endmodule

// File: tb/tb_ex_alu_arb.sv
// Randomized and directed bench for ex_alu_arb against a transaction-level model.
// Latency: model expects responses 2 cycles after a handshake.
// Backpressure: rsp_ready and flush are driven both deliberately and at random.
module tb_ex_alu_arb;
    localparam int XLEN = 64;
    localparam int OPW  = 4;
    localparam int TAGW = 3;

    localparam logic [3:0] DO_ADD = 4'd0;
    localparam logic [3:0] DO_SUB = 4'd1;
    localparam logic [3:0] DO_AND = 4'd2;
    localparam logic [3:0] DO_OR  = 4'd3;
    localparam logic [3:0] DO_XOR = 4'd4;

    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  tag;
    } req_s;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ex_alu_arb_if #(.XLEN(XLEN), .OPW(OPW), .TAGW(TAGW)) bus ();

    ex_alu_arb #(.XLEN(XLEN), .OPW(OPW), .TAGW(TAGW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Behavioural ALU attached to the arbiter's ALU port
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            DO_ADD:  return a + b;
            DO_SUB:  return a - b;
            DO_AND:  return a & b;
            DO_OR:   return a | b;
            DO_XOR:  return a ^ b;
            default: return a;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    // Transaction model: one op slot, aged in cycles since its handshake
    bit          m_has;
    int          m_age;
    bit          m_last;
    logic [3:0]  m_op;
    logic [63:0] m_a;
    logic [63:0] m_b;
    logic [63:0] m_res;
    logic [2:0]  m_tag;
    bit          m_src;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic req_s mk(input bit v, input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic [2:0] tag);
        req_s r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.tag = tag;
        return r;
    endfunction

    function automatic req_s rnd_req();
        return mk($urandom_range(99) < 60, 4'($urandom_range(5)), {$urandom, $urandom},
                  {$urandom, $urandom}, 3'($urandom_range(7)));
    endfunction

    task automatic model_reset();
        m_has = 1'b0; m_age = 0; m_last = 1'b1;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_tag = '0; m_src = 1'b0;
    endtask

    // One cycle: drive after negedge, compare against the model, then advance the model
    task automatic step(input req_s r0, input req_s r1, input bit rr, input bit fl);
        bit can, win, anyv, exp_rv, consumed;
        @(negedge clk);
        bus.req0_valid = r0.v; bus.req0_op = r0.op; bus.req0_a = r0.a;
        bus.req0_b = r0.b; bus.req0_tag = r0.tag;
        bus.req1_valid = r1.v; bus.req1_op = r1.op; bus.req1_a = r1.a;
        bus.req1_b = r1.b; bus.req1_tag = r1.tag;
        bus.rsp_ready = rr;
        flush = fl;
        #1;
        can  = !fl && (!m_has || (m_age >= 2 && rr));
        anyv = r0.v || r1.v;
        win  = (r0.v && !r1.v) ? 1'b0 : (r1.v && !r0.v) ? 1'b1 : !m_last;
        if (r0.v) check_val("rdy0", 64'(bus.req0_ready), 64'(can && !win));
        if (r1.v) check_val("rdy1", 64'(bus.req1_ready), 64'(can && win));
        check_val("rdy_excl", 64'(bus.req0_ready && bus.req1_ready), 64'(0));
        exp_rv = m_has && m_age >= 2;
        check_val("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check_val("rsp_result", bus.rsp_result, m_res);
            check_val("rsp_tag", 64'(bus.rsp_tag), 64'(m_tag));
            check_val("rsp_src", 64'(bus.rsp_src), 64'(m_src));
        end
        check_val("alu_op", 64'(bus.alu_op), 64'(m_op));
        check_val("alu_a", bus.alu_a, m_a);
        check_val("alu_b", bus.alu_b, m_b);
        if (fl) begin
            m_has = 1'b0;
        end else begin
            consumed = m_has && m_age >= 2 && rr;
            if (m_has && m_age == 1) m_age = 2;
            if (consumed) m_has = 1'b0;
            if (can && anyv) begin
                m_op  = win ? r1.op  : r0.op;
                m_a   = win ? r1.a   : r0.a;
                m_b   = win ? r1.b   : r0.b;
                m_tag = win ? r1.tag : r0.tag;
                m_src = win;
                m_res = alu_f(m_op, m_a, m_b);
                m_has = 1'b1;
                m_age = 1;
                m_last = win;
            end
        end
    endtask

    req_s idle_r;

    task automatic drain();
        repeat (3) step(idle_r, idle_r, 1'b1, 1'b0);
    endtask

    // Async reset pulse between edges, straddling one rising edge
    task automatic reset_pulse();
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_val("rst_rsp_result", bus.rsp_result, 64'(0));
        check_val("rst_rsp_tag", 64'(bus.rsp_tag), 64'(0));
        check_val("rst_rsp_src", 64'(bus.rsp_src), 64'(0));
        check_val("rst_alu_a", bus.alu_a, 64'(0));
        check_val("rst_alu_op", 64'(bus.alu_op), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    int    rsp_cyc[$];
    bit    rsp_srcs[$];
    bit    exp_src_seq [4];

    initial begin
        idle_r = mk(1'b0, DO_ADD, 64'd0, 64'd0, 3'd0);
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_val("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_val("reset_rsp_result", bus.rsp_result, 64'(0));
        check_val("reset_alu_b", bus.alu_b, 64'(0));
        #2 rst_n = 1'b1;

        // Round-robin with both ports saturated
        for (int i = 0; i < 9; i++) begin
            step(mk(1'b1, DO_ADD, 64'(i), 64'd1, 3'(i)), mk(1'b1, DO_XOR, 64'(i), 64'hF0, 3'(i)), 1'b1, 1'b0);
            if (i == 0) check_val("t2_first_grant_p0", 64'(bus.req0_ready), 64'(1));
            if (bus.rsp_valid) begin
                rsp_cyc.push_back(i);
                rsp_srcs.push_back(bus.rsp_src);
            end
        end
        exp_src_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
        check_val("t2_rsp_count", 64'(rsp_cyc.size() >= 4), 64'(1));
        for (int k = 0; k < 4 && k < rsp_srcs.size(); k++) begin
            check_val("t2_src_seq", 64'(rsp_srcs[k]), 64'(exp_src_seq[k]));
            if (k > 0) check_val("t2_rsp_gap", 64'(rsp_cyc[k] - rsp_cyc[k-1]), 64'(2));
        end
        drain();

        // Single op on port 0
        step(mk(1'b1, DO_ADD, 64'd5, 64'd7, 3'd2), idle_r, 1'b0, 1'b0);
        check_val("t1_rdy0", 64'(bus.req0_ready), 64'(1));
        step(idle_r, idle_r, 1'b0, 1'b0);
        check_val("t1_alu_a", bus.alu_a, 64'd5);
        check_val("t1_alu_b", bus.alu_b, 64'd7);
        step(idle_r, idle_r, 1'b0, 1'b0);
        check_val("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check_val("t1_result", bus.rsp_result, 64'd12);
        check_val("t1_tag", 64'(bus.rsp_tag), 64'd2);
        check_val("t1_src", 64'(bus.rsp_src), 64'd0);
        drain();

        // Backpressure on the response
        step(mk(1'b1, DO_ADD, 64'hDE00, 64'hAD, 3'd1), idle_r, 1'b0, 1'b0);
        step(idle_r, idle_r, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(idle_r, mk(1'b1, DO_OR, 64'h1, 64'h2, 3'd4), 1'b0, 1'b0);
            check_val("t3_hold_result", bus.rsp_result, 64'hDEAD);
            check_val("t3_hold_valid", 64'(bus.rsp_valid), 64'(1));
            check_val("t3_hold_rdy1", 64'(bus.req1_ready), 64'(0));
        end
        step(idle_r, mk(1'b1, DO_OR, 64'h1, 64'h2, 3'd4), 1'b1, 1'b0);
        check_val("t3_release_rdy1", 64'(bus.req1_ready), 64'(1));
        drain();

        // Flush in EXEC, then flush in RESP together with rsp_ready
        step(mk(1'b1, DO_ADD, 64'd1, 64'd2, 3'd1), idle_r, 1'b1, 1'b0);
        step(mk(1'b1, DO_ADD, 64'd9, 64'd9, 3'd3), idle_r, 1'b1, 1'b1);
        check_val("t4_flush_rdy0", 64'(bus.req0_ready), 64'(0));
        step(mk(1'b1, DO_ADD, 64'd10, 64'd20, 3'd4), idle_r, 1'b1, 1'b0);
        check_val("t4_no_rsp", 64'(bus.rsp_valid), 64'(0));
        check_val("t4_reaccept", 64'(bus.req0_ready), 64'(1));
        step(idle_r, idle_r, 1'b0, 1'b0);
        step(idle_r, idle_r, 1'b0, 1'b0);
        check_val("t4_lat2_valid", 64'(bus.rsp_valid), 64'(1));
        check_val("t4_lat2_result", bus.rsp_result, 64'd30);
        step(idle_r, idle_r, 1'b1, 1'b1);
        step(idle_r, idle_r, 1'b1, 1'b0);
        check_val("t4_resp_flushed", 64'(bus.rsp_valid), 64'(0));
        drain();

        // Async reset while a response is held
        step(mk(1'b1, DO_ADD, 64'd100, 64'd1, 3'd5), idle_r, 1'b0, 1'b0);
        step(idle_r, idle_r, 1'b0, 1'b0);
        step(idle_r, idle_r, 1'b0, 1'b0);
        check_val("t5_in_resp", 64'(bus.rsp_valid), 64'(1));
        reset_pulse();

        // Port 1 alone right after reset
        step(idle_r, mk(1'b1, DO_SUB, 64'd3, 64'd5, 3'd6), 1'b0, 1'b0);
        check_val("t6_rdy1", 64'(bus.req1_ready), 64'(1));
        step(idle_r, idle_r, 1'b0, 1'b0);
        step(idle_r, idle_r, 1'b0, 1'b0);
        check_val("t6_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("t6_src", 64'(bus.rsp_src), 64'd1);
        drain();

        // After port 1 was served the next tie goes to port 0
        step(mk(1'b1, DO_AND, 64'hFF, 64'h0F, 3'd1), mk(1'b1, DO_OR, 64'h1, 64'h2, 3'd2), 1'b1, 1'b0);
        check_val("t5_tie_p0", 64'(bus.req0_ready), 64'(1));
        drain();

        // Random traffic with random backpressure, flushes and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199) == 0) begin
                reset_pulse();
            end else begin
                step(rnd_req(), rnd_req(), $urandom_range(99) < 70, $urandom_range(99) < 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_alu_arb.md
Name: ex_alu_arb

Overview:
- Shares the single execute-stage ALU between two requesters: port 0 is the main pipeline issue, port 1 is the address-generation / branch-target helper.
- Each port uses a valid/ready handshake into a round-robin arbiter.
- The granted operation is captured, driven onto the ALU for one cycle, and the ALU result is registered into a tagged response held until consumed.
- A pipeline flush discards all in-flight work.

Parameters:
- XLEN, 64, operand and result width.
- OPW, 4, ALU opcode width (DO_* encodings).
- TAGW, 3, requester tag width, returned unchanged with the result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard in-flight operation; synchronous, highest priority.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 accepted this cycle when valid & ready.
- req0_op  in  OPW  port 0 ALU opcode.
- req0_a  in  XLEN  port 0 operand A.
- req0_b  in  XLEN  port 0 operand B.
- req0_tag  in  TAGW  port 0 tag.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as port 0, for port 1.
- alu_op  out  OPW  opcode to the ALU.
- alu_a  out  XLEN  operand A to the ALU.
- alu_b  out  XLEN  operand B to the ALU.
- alu_result  in  XLEN  combinational ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  XLEN  registered result.
- rsp_tag  out  TAGW  tag of the completed operation.
- rsp_src  out  1  0 = port 0, 1 = port 1.

Behaviour:
- **FSM states:**
  - IDLE: no work.
  - EXEC: captured op on the ALU.
  - RESP: result held.
- **Reset (async, rst_n=0):**
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_src=0.
  - Capture registers and alu_op/alu_a/alu_b = 0.
  - Reset mid-operation drops the in-flight op with no response.
- **Accept window:** `can_accept = (state==IDLE) | (state==RESP & rsp_ready)`, and flush=0.
- **Arbitration:**
  - reqN_ready = can_accept & grant==N (ready is combinational).
  - Only one port is ready per cycle; a non-granted valid port sees ready=0.
  - Only one valid: that port is granted.
  - Both valid: grant = ~last_grant.
  - last_grant updates only on an accepted handshake.
- **Accept at cycle N:**
  - Capture op/a/b/tag/src.
  - state -> EXEC at N+1.
- **EXEC (cycle N+1):**
  - alu_op/a/b driven from the capture registers.
  - alu_result registered into rsp_result, with rsp_tag and rsp_src.
  - state -> RESP, rsp_valid=1 at N+2.
- **Latency:** accept-to-rsp_valid is 2 cycles.
- **Throughput:** 1 op per 2 cycles. Back-to-back is possible when accept coincides with the response handshake.
- **ALU inputs outside EXEC:** alu_op/a/b hold their last values (no toggling); the ALU output is ignored.
- **RESP:**
  - rsp_valid stays 1 and rsp_result/tag/src stay stable until rsp_ready=1.
  - On rsp_ready=1: if a request is accepted the same cycle, state -> EXEC; otherwise state -> IDLE, rsp_valid=0.
- **Flush:**
  - From any state: state -> IDLE and rsp_valid=0 at the next edge.
  - No request is accepted in the flush cycle (both readys=0).
  - The in-flight op is dropped; last_grant is unchanged.
- **Simultaneous flush & rsp_ready:** the flush wins and the response is still discarded. The consumer is required to ignore a response in its own flush cycle.
- **Datapath:** the block never alters operands, result width, or tag; tags are not checked for uniqueness.
- **Assertions:**
  - req ready never high for both ports in one cycle.
  - rsp payload stable while rsp_valid & !rsp_ready.
  - state never leaves EXEC without passing through RESP or IDLE-on-flush.

Test Plan:
1. **Single op, port 0:** req0 op=DO_ADD a=5 b=7 tag=2 at cycle 1, ALU model returns a+b.
   - req0_ready=1 at cycle 1; alu_a=5, alu_b=7 at cycle 2.
   - rsp_valid=1 at cycle 3 with result=12, tag=2, src=0.
2. **Round-robin:** both ports valid continuously, rsp_ready=1.
   - Grants alternate 0,1,0,1; rsp_src sequence 0,1,0,1, one response every 2 cycles.
   - The first grant after reset is port 0.
3. **Backpressure:** rsp_ready=0 for 5 cycles after rsp_valid, result=0xDEAD.
   - rsp_result stays 0xDEAD and rsp_valid stays 1; req readys stay 0.
   - On rsp_ready=1 with req1 valid, req1_ready=1 the same cycle.
4. **Flush:**
   - Flush in EXEC: no response ever appears; the next cycle is IDLE and a new req0 accepts with latency 2.
   - Flush in RESP: rsp_valid=0 next cycle.
5. **Async reset mid-RESP:** rst_n low for half a cycle.
   - rsp_valid=0 immediately, all outputs 0.
   - After release, the first tie goes to port 0.
6. **Port 1 alone:** req1 op=DO_SUB a=3 b=5 with req0 idle.
   - Granted despite last_grant=1.
   - Result 0xFFFF_FFFF_FFFF_FFFE, src=1.
